// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the memory-access stage:
//   - data-bus and register-file widths
//   - MEM_SIZE_* access-size encodings (2'b11 is handled as a word)
//   - FSM state type for the bus handshake
//   - helpers that align the low address bits to the access size and
//     report a misaligned access
package mem_stage_pkg;

  localparam int unsigned DBUS_ADDR_W   = 32;
  localparam int unsigned REG_BUS_WIDTH = 32;
  localparam int unsigned REG_ADDR_BUS  = 5;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Clear the address bits that fall below the access size.
  function automatic logic [1:0] mem_align_lo(input logic [1:0] size,
                                              input logic [1:0] lo);
    case (size)
      MEM_SIZE_B: return lo;
      MEM_SIZE_H: return {lo[1], 1'b0};
      default:    return 2'b00;
    endcase
  endfunction

  // An access is misaligned when aligning it would change the address.
  function automatic logic mem_is_misaligned(input logic [1:0] size,
                                             input logic [1:0] lo);
    return mem_align_lo(size, lo) != lo;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align
// Purely combinational lane logic for the memory stage.
//   Store side: byte enables and lane-replicated write data.
//   Load side : lane selection and sign/zero extension of read data.
// Ports:
//   i_size     access size (MEM_SIZE_*; 2'b11 acts as a word)
//   i_unsigned zero-extend loads (ignored for words)
//   i_addr_lo  low address bits, already aligned to the access size
//   i_wdata    store data, low bits significant
//   i_rdata    raw bus read data
//   o_be       byte enables
//   o_wdata    replicated store data
//   o_rdata    extracted and extended load data
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = REG_BUS_WIDTH
) (
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] w_rshift;
  logic              w_sign_b;
  logic              w_sign_h;

  // Bring the addressed lane down to bit 0 before extension.
  assign w_rshift = i_rdata >> {i_addr_lo, 3'b000};
  assign w_sign_b = ~i_unsigned & w_rshift[7];
  assign w_sign_h = ~i_unsigned & w_rshift[15];

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    case (i_size)
      MEM_SIZE_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {(DATA_W/8){i_wdata[7:0]}};
        o_rdata = {{(DATA_W-8){w_sign_b}}, w_rshift[7:0]};
      end
      MEM_SIZE_H: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {(DATA_W/16){i_wdata[15:0]}};
        o_rdata = {{(DATA_W-16){w_sign_h}}, w_rshift[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
// Memory-access stage behind the execute unit.
//   - Non-memory results are registered to write-back with 1-cycle latency.
//   - Loads and stores run a req/gnt/rvalid bus handshake (IDLE/REQ/WAIT).
//     The pipeline is stalled until the response arrives.
// Optional build macro MEM_MISALIGN_CHECK_EN:
//   - defined:   misaligned half/word accesses are not issued. The stage
//                reports them on misalign_o / misalign_addr_o instead.
//   - undefined: low address bits below the access size are forced to zero.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   valid_i, rd_we_i, rd_addr_i,
//   rd_data_i                          execute result
//   mem_req_i, mem_we_i, mem_size_i,
//   mem_unsigned_i, mem_addr_i,
//   mem_wdata_i                        load/store control
//   stall_o                            upstream hold
//   dbus_*                             data bus request/response
//   wb_valid_o, rd_we_o, rd_addr_o,
//   rd_data_o                          write-back entry
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = DBUS_ADDR_W,
  parameter int unsigned DATA_W = REG_BUS_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              stall_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o,
`endif
  output logic              wb_valid_o,
  output logic              rd_we_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o
);

  mem_state_e        r_state;
  logic              r_is_store;
  logic              r_rd_we;
  logic [4:0]        r_rd_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_addr_lo;

  logic [1:0]        w_addr_lo;
  logic [1:0]        w_sel_size;
  logic [1:0]        w_sel_lo;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;
  logic              w_done;
`ifdef MEM_MISALIGN_CHECK_EN
  logic              w_misaligned;

  assign w_misaligned = mem_is_misaligned(mem_size_i, mem_addr_i[1:0]);
`endif

  assign w_addr_lo = mem_align_lo(mem_size_i, mem_addr_i[1:0]);

  // A single lane unit is shared. The store path is only consumed in IDLE
  // (from live inputs), and the load path only while an access is
  // outstanding (from the captured op).
  assign w_sel_size = (r_state == ST_IDLE) ? mem_size_i : r_size;
  assign w_sel_lo   = (r_state == ST_IDLE) ? w_addr_lo  : r_addr_lo;

  mem_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_size     (w_sel_size),
    .i_unsigned (r_unsigned),
    .i_addr_lo  (w_sel_lo),
    .i_wdata    (mem_wdata_i),
    .i_rdata    (dbus_rdata_i),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data)
  );

  // Response accepted: either in WAIT, or together with the grant in REQ.
  assign w_done = ((r_state == ST_REQ) & dbus_gnt_i & dbus_rvalid_i) |
                  ((r_state == ST_WAIT) & dbus_rvalid_i);

  assign stall_o = (r_state != ST_IDLE) &
                   ~((r_state == ST_WAIT) & dbus_rvalid_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_is_store   <= 1'b0;
      r_rd_we      <= 1'b0;
      r_rd_addr    <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_addr_lo    <= '0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      rd_we_o      <= 1'b0;
      rd_addr_o    <= '0;
      rd_data_o    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (valid_i && !mem_req_i) begin
            wb_valid_o <= 1'b1;
            rd_we_o    <= rd_we_i;
            rd_addr_o  <= rd_addr_i;
            rd_data_o  <= rd_data_i;
          end else if (valid_i && mem_req_i) begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (w_misaligned) begin
              wb_valid_o      <= 1'b1;
              rd_we_o         <= 1'b0;
              rd_addr_o       <= rd_addr_i;
              rd_data_o       <= '0;
              misalign_o      <= 1'b1;
              misalign_addr_o <= mem_addr_i;
            end else
`endif
            begin
              r_is_store   <= mem_we_i;
              r_rd_we      <= rd_we_i;
              r_rd_addr    <= rd_addr_i;
              r_size       <= mem_size_i;
              r_unsigned   <= mem_unsigned_i;
              r_addr_lo    <= w_addr_lo;
              dbus_req_o   <= 1'b1;
              dbus_we_o    <= mem_we_i;
              dbus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              dbus_be_o    <= w_be;
              dbus_wdata_o <= w_wdata;
              r_state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
        end
        default: r_state <= ST_IDLE;
      endcase

      // Completion overrides the REQ->WAIT move when gnt and rvalid coincide.
      if (w_done) begin
        wb_valid_o <= 1'b1;
        rd_we_o    <= r_is_store ? 1'b0 : r_rd_we;
        rd_addr_o  <= r_rd_addr;
        rd_data_o  <= r_is_store ? '0 : w_load_data;
        r_state    <= ST_IDLE;
      end
    end
  end

endmodule
